// File: rtl/ps2_key_tx_pkg.sv
// Shared definitions for the PS/2 key transmitter: key codes, set-2 scan codes, FSM states.
// The FSM state list depends on PS2_TX_BREAK_EN (break prefix/gap states only when enabled).
package ps2_key_pkg;

  localparam logic [3:0] KEY_0     = 4'd0;
  localparam logic [3:0] KEY_1     = 4'd1;
  localparam logic [3:0] KEY_2     = 4'd2;
  localparam logic [3:0] KEY_3     = 4'd3;
  localparam logic [3:0] KEY_4     = 4'd4;
  localparam logic [3:0] KEY_5     = 4'd5;
  localparam logic [3:0] KEY_6     = 4'd6;
  localparam logic [3:0] KEY_7     = 4'd7;
  localparam logic [3:0] KEY_8     = 4'd8;
  localparam logic [3:0] KEY_9     = 4'd9;
  localparam logic [3:0] KEY_ENTER = 4'd10;
  localparam logic [3:0] KEY_A     = 4'd11;
  localparam logic [3:0] KEY_S     = 4'd12;
  localparam logic [3:0] KEY_M     = 4'd13;

  localparam logic [7:0] SC_0     = 8'h70;
  localparam logic [7:0] SC_1     = 8'h69;
  localparam logic [7:0] SC_2     = 8'h72;
  localparam logic [7:0] SC_3     = 8'h7A;
  localparam logic [7:0] SC_4     = 8'h6B;
  localparam logic [7:0] SC_5     = 8'h73;
  localparam logic [7:0] SC_6     = 8'h74;
  localparam logic [7:0] SC_7     = 8'h6C;
  localparam logic [7:0] SC_8     = 8'h75;
  localparam logic [7:0] SC_9     = 8'h7D;
  localparam logic [7:0] SC_ENTER = 8'h5A;
  localparam logic [7:0] SC_A     = 8'h1C;
  localparam logic [7:0] SC_S     = 8'h1B;
  localparam logic [7:0] SC_M     = 8'h3A;
  localparam logic [7:0] SC_BREAK = 8'hF0;

`ifdef PS2_TX_BREAK_EN
  typedef enum logic [1:0] {
    ST_IDLE         = 2'd0,
    ST_FRAME_PREFIX = 2'd1,
    ST_GAP          = 2'd2,
    ST_FRAME_CODE   = 2'd3
  } tx_state_e;
`else
  typedef enum logic [0:0] {
    ST_IDLE       = 1'b0,
    ST_FRAME_CODE = 1'b1
  } tx_state_e;
`endif

  function automatic logic odd_parity(input logic [7:0] b);
    return ~^b;
  endfunction

  function automatic logic key_is_valid(input logic [3:0] c);
    return (c <= KEY_M);
  endfunction

  function automatic logic [7:0] encode_key(input logic [3:0] c);
    logic [7:0] sc;
    case (c)
      KEY_0:     sc = SC_0;
      KEY_1:     sc = SC_1;
      KEY_2:     sc = SC_2;
      KEY_3:     sc = SC_3;
      KEY_4:     sc = SC_4;
      KEY_5:     sc = SC_5;
      KEY_6:     sc = SC_6;
      KEY_7:     sc = SC_7;
      KEY_8:     sc = SC_8;
      KEY_9:     sc = SC_9;
      KEY_ENTER: sc = SC_ENTER;
      KEY_A:     sc = SC_A;
      KEY_S:     sc = SC_S;
      KEY_M:     sc = SC_M;
      default:   sc = 8'h00;
    endcase
    return sc;
  endfunction

endpackage

// File: rtl/ps2_key_tx_if.sv
// Key request handshake, status flags and PS/2 line levels of ps2_key_tx.
interface ps2_key_tx_if;
  logic [3:0] key_code;
  logic       key_release;
  logic       key_valid;
  logic       key_ready;
  logic       busy;
  logic       bad_code;
  logic       ps2_clk_o;
  logic       ps2_data_o;

  modport master (
    output key_code, key_release, key_valid,
    input  key_ready, busy, bad_code, ps2_clk_o, ps2_data_o
  );

  modport slave (
    input  key_code, key_release, key_valid,
    output key_ready, busy, bad_code, ps2_clk_o, ps2_data_o
  );
endinterface

// File: rtl/ps2_frame_tx.sv
// Serializes one byte as an 11-bit PS/2 frame (start, 8 data LSB first, odd parity, stop).
// done_o marks the last cycle of the stop slot so the caller can react on the same edge.
module ps2_frame_tx
  import ps2_key_pkg::*;
#(
  parameter int HALF_PERIOD = 3000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start_i,
  input  logic [7:0] byte_i,
  output logic       ps2_clk_o,
  output logic       ps2_data_o,
  output logic       done_o
);

  localparam int SLOT = 2 * HALF_PERIOD;
  localparam int CW   = (SLOT > 1) ? $clog2(SLOT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(SLOT - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(HALF_PERIOD - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [3:0]    BIT_LAST = 4'd10;

  logic          active_q;
  logic [CW-1:0] cnt_q;
  logic [3:0]    bit_q;
  logic [9:0]    shift_q;
  logic          clk_q;
  logic          data_q;

  assign done_o     = active_q && (bit_q == BIT_LAST) && (cnt_q == CNT_LAST);
  assign ps2_clk_o  = clk_q;
  assign ps2_data_o = data_q;

  // Slot timing and shift register; shift_q holds the bits still to send after the start bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      active_q <= 1'b0;
      cnt_q    <= {CW{1'b0}};
      bit_q    <= 4'd0;
      shift_q  <= 10'd0;
      clk_q    <= 1'b1;
      data_q   <= 1'b1;
    end else if (!active_q) begin
      cnt_q  <= {CW{1'b0}};
      bit_q  <= 4'd0;
      clk_q  <= 1'b1;
      data_q <= 1'b1;
      if (start_i) begin
        active_q <= 1'b1;
        data_q   <= 1'b0;
        shift_q  <= {1'b1, odd_parity(byte_i), byte_i};
      end
    end else if (cnt_q == CNT_LAST) begin
      cnt_q <= {CW{1'b0}};
      clk_q <= 1'b1;
      if (bit_q == BIT_LAST) begin
        active_q <= 1'b0;
        data_q   <= 1'b1;
      end else begin
        bit_q   <= bit_q + 4'd1;
        data_q  <= shift_q[0];
        shift_q <= {1'b0, shift_q[9:1]};
      end
    end else begin
      cnt_q <= cnt_q + CNT_ONE;
      if (cnt_q == CNT_HALF) begin
        clk_q <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/ps2_key_tx.sv
// PS/2 keyboard transmitter top: key handshake, scan-code encoder and event FSM.
// PS2_TX_BREAK_EN enables F0-prefixed break sequences; otherwise break events send nothing.
module ps2_key_tx
  import ps2_key_pkg::*;
#(
  parameter int HALF_PERIOD = 3000
`ifdef PS2_TX_BREAK_EN
  , parameter int GAP = 6000
`endif
) (
  input logic          clk,
  input logic          rst,
  ps2_key_tx_if.slave  kif
);

`ifdef PS2_TX_BREAK_EN
  localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP - 1);
  localparam logic [GW-1:0] GAP_ONE  = GW'(1);

  logic [GW-1:0] gap_cnt_q;
  logic [3:0]    code_q;
`endif

  tx_state_e  state_q;
  logic       key_ready_q;
  logic       busy_q;
  logic       bad_code_q;

  logic       accept_s;
  logic       code_ok_s;
  logic       frame_start_s;
  logic [7:0] frame_byte_s;
  logic       frame_done_s;
  logic       ps2_clk_s;
  logic       ps2_data_s;

  // First frame starts on the acceptance edge so the start bit appears one cycle later.
  always_comb begin
    accept_s      = kif.key_valid && key_ready_q && (state_q == ST_IDLE);
    code_ok_s     = key_is_valid(kif.key_code);
    frame_start_s = 1'b0;
    frame_byte_s  = encode_key(kif.key_code);
`ifdef PS2_TX_BREAK_EN
    if (accept_s && code_ok_s) begin
      frame_start_s = 1'b1;
      frame_byte_s  = kif.key_release ? SC_BREAK : encode_key(kif.key_code);
    end else if ((state_q == ST_GAP) && (gap_cnt_q == GAP_LAST)) begin
      frame_start_s = 1'b1;
      frame_byte_s  = encode_key(code_q);
    end else begin
      frame_start_s = 1'b0;
    end
`else
    if (accept_s && code_ok_s && !kif.key_release) begin
      frame_start_s = 1'b1;
    end else begin
      frame_start_s = 1'b0;
    end
`endif
  end

  // Event FSM with registered handshake and status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      key_ready_q <= 1'b1;
      busy_q      <= 1'b0;
      bad_code_q  <= 1'b0;
`ifdef PS2_TX_BREAK_EN
      gap_cnt_q   <= {GW{1'b0}};
      code_q      <= 4'd0;
`endif
    end else begin
      bad_code_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (accept_s) begin
            key_ready_q <= 1'b0;
            busy_q      <= 1'b1;
            if (!code_ok_s) begin
              bad_code_q <= 1'b1;
            end else if (kif.key_release) begin
`ifdef PS2_TX_BREAK_EN
              state_q <= ST_FRAME_PREFIX;
              code_q  <= kif.key_code;
`endif
            end else begin
              state_q <= ST_FRAME_CODE;
            end
          end else begin
            // Also closes the one-cycle busy window of frameless events.
            key_ready_q <= 1'b1;
            busy_q      <= 1'b0;
          end
        end
`ifdef PS2_TX_BREAK_EN
        ST_FRAME_PREFIX: begin
          if (frame_done_s) begin
            state_q   <= ST_GAP;
            gap_cnt_q <= {GW{1'b0}};
          end
        end
        ST_GAP: begin
          if (gap_cnt_q == GAP_LAST) begin
            state_q <= ST_FRAME_CODE;
          end else begin
            gap_cnt_q <= gap_cnt_q + GAP_ONE;
          end
        end
`endif
        ST_FRAME_CODE: begin
          if (frame_done_s) begin
            state_q     <= ST_IDLE;
            key_ready_q <= 1'b1;
            busy_q      <= 1'b0;
          end
        end
        default: begin
          state_q     <= ST_IDLE;
          key_ready_q <= 1'b1;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  ps2_frame_tx #(
    .HALF_PERIOD (HALF_PERIOD)
  ) u_frame (
    .clk        (clk),
    .rst        (rst),
    .start_i    (frame_start_s),
    .byte_i     (frame_byte_s),
    .ps2_clk_o  (ps2_clk_s),
    .ps2_data_o (ps2_data_s),
    .done_o     (frame_done_s)
  );

  assign kif.key_ready  = key_ready_q;
  assign kif.busy       = busy_q;
  assign kif.bad_code   = bad_code_q;
  assign kif.ps2_clk_o  = ps2_clk_s;
  assign kif.ps2_data_o = ps2_data_s;

endmodule

// File: tb/tb_ps2_key_tx.sv
// Randomized bench for ps2_key_tx: a per-cycle expected waveform is built from the protocol rules.
// Works with and without PS2_TX_BREAK_EN.
module tb_ps2_key_tx;
  import ps2_key_pkg::*;

  localparam int HP = 4;
  localparam int GP = 8;
  // Expected vector layout: {ps2_clk, ps2_data, key_ready, busy, bad_code}
  localparam logic [4:0] IDLE_V = 5'b11100;

  logic clk;
  logic rst;
  ps2_key_tx_if kif ();

`ifdef PS2_TX_BREAK_EN
  ps2_key_tx #(.HALF_PERIOD(HP), .GAP(GP)) dut (.clk(clk), .rst(rst), .kif(kif));
`else
  ps2_key_tx #(.HALF_PERIOD(HP)) dut (.clk(clk), .rst(rst), .kif(kif));
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  logic [4:0] exp_q[$];
  logic prev_ready = 1'b1;
  logic acc_f = 1'b0;

  task automatic check_eq(input string tag, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] ref_scan(input int c);
    case (c)
      0: return 8'h70;   1: return 8'h69;   2: return 8'h72;   3: return 8'h7A;
      4: return 8'h6B;   5: return 8'h73;   6: return 8'h74;   7: return 8'h6C;
      8: return 8'h75;   9: return 8'h7D;  10: return 8'h5A;  11: return 8'h1C;
     12: return 8'h1B;  13: return 8'h3A;
      default: return 8'h00;
    endcase
  endfunction

  task automatic push_frame(input logic [7:0] b);
    logic [10:0] fr;
    fr = {1'b1, ~^b, b, 1'b0};
    for (int i = 0; i < 11; i++)
      for (int c = 0; c < 2 * HP; c++)
        exp_q.push_back({(c < HP) ? 1'b1 : 1'b0, fr[i], 3'b010});
  endtask

  task automatic build_event(input int code, input logic rel);
    if (code > 13) begin
      exp_q.push_back(5'b11011);
    end else if (rel) begin
`ifdef PS2_TX_BREAK_EN
      push_frame(8'hF0);
      for (int g = 0; g < GP; g++) exp_q.push_back(5'b11010);
      push_frame(ref_scan(code));
`else
      exp_q.push_back(5'b11010);
`endif
    end else begin
      push_frame(ref_scan(code));
    end
  endtask

  task automatic step();
    logic [4:0] exp_v;
    @(posedge clk);
    acc_f = !rst && kif.key_valid && prev_ready;
    if (rst) exp_q.delete();
    else if (acc_f) build_event(int'(kif.key_code), kif.key_release);
    #1;
    exp_v = (exp_q.size() > 0) ? exp_q.pop_front() : IDLE_V;
    check_eq("lines_ready_busy_bad", {3'b000, kif.ps2_clk_o, kif.ps2_data_o,
             kif.key_ready, kif.busy, kif.bad_code}, {3'b000, exp_v});
    prev_ready = exp_v[2];
  endtask

  task automatic send(input logic [3:0] code, input logic rel);
    int n;
    kif.key_code = code;
    kif.key_release = rel;
    kif.key_valid = 1'b1;
    n = 0;
    do begin
      step();
      n++;
    end while (!acc_f && n < 400);
    check_eq("accepted", {7'd0, acc_f}, 8'd1);
    kif.key_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    rst = 1'b1;
    kif.key_code = 4'd0;
    kif.key_release = 1'b0;
    kif.key_valid = 1'b0;
    idle(3);
    rst = 1'b0;
    idle(2);

    // Directed cases
    send(4'd0, 1'b0);  idle(95);
    send(4'd13, 1'b1); idle(200);
    send(4'd15, 1'b0); idle(4);
    send(4'd3, 1'b1);  idle(4);
    send(4'd3, 1'b0);  idle(41);
    rst = 1'b1; step(); rst = 1'b0; step();
    send(4'd10, 1'b0); idle(95);

    // Random events; sometimes keep key_valid high and scramble the inputs mid-frame
    for (int ev = 0; ev < 40; ev++) begin
      send(4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 2) == 0) begin
        kif.key_valid = 1'b1;
        for (int k = 0; k < 30; k++) begin
          kif.key_code = 4'($urandom_range(0, 15));
          kif.key_release = 1'($urandom_range(0, 1));
          step();
        end
        kif.key_valid = 1'b0;
      end else begin
        idle($urandom_range(0, 3));
      end
    end
    kif.key_valid = 1'b0;
    idle(250);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
